memory_cycle: RTL and testbench

Memory stage of the five-stage RISC-V pipeline. Consumes the execute-to-memory register outputs, performs loads and stores over a request/acknowledge data-memory port, and drives the memory-to-writeback register. It also generates a stall for the upstream stages while a memory access is outstanding. Non-memory instructions pass through in one cycle.

---
 rtl/memory_cycle.sv | 132 +++++++++++++
 tb/tb_memory_cycle.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// Memory stage: request/ack data-memory access with upstream stall and M/W register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module memory_cycle #(
  parameter int XLEN = 32,
  parameter int RDW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite_M,
  input  logic            ResultSrc_M,
  input  logic            MemWrite_M,
  input  logic [XLEN-1:0] AluResult_M,
  input  logic [XLEN-1:0] WriteData_M,
  input  logic [RDW-1:0]  RD_M,
  input  logic [XLEN-1:0] PCPlus4_M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            Stall_M,
  output logic            RegWrite_W,
  output logic            ResultSrc_W,
  output logic [XLEN-1:0] AluResult_W,
  output logic [XLEN-1:0] ReadData_W,
  output logic [XLEN-1:0] PCPlus4_W,
  output logic [RDW-1:0]  RD_W,
  output logic            Misalign_W
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic              we_q, load_q;
  logic              regwrite_q, resultsrc_q, misalign_q;
  logic [XLEN-1:0]   alu_q, rdata_q, pc4_q;
  logic [RDW-1:0]    rd_q;

  logic mem_op, is_load, misalign, issue;

  assign mem_op  = MemWrite_M | (ResultSrc_M & RegWrite_M);
  assign is_load = ResultSrc_M & RegWrite_M & ~MemWrite_M;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (AluResult_M[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign issue = mem_op & ~misalign;

  // Ack only matters while an access is outstanding; in IDLE it is ignored.
  assign Stall_M = (state_q == IDLE) ? issue : ~dmem_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue)    state_d = BUSY;
      BUSY:    if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      load_q      <= 1'b0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      misalign_q  <= 1'b0;
      alu_q       <= '0;
      rdata_q     <= '0;
      pc4_q       <= '0;
      rd_q        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (issue) begin
            addr_q     <= AluResult_M;
            wdata_q    <= WriteData_M;
            we_q       <= MemWrite_M;
            load_q     <= is_load;
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
          end else begin
            regwrite_q  <= RegWrite_M & ~misalign;
            misalign_q  <= misalign;
            resultsrc_q <= ResultSrc_M;
            alu_q       <= AluResult_M;
            pc4_q       <= PCPlus4_M;
            rd_q        <= RD_M;
          end
        end
        BUSY: begin
          misalign_q <= 1'b0;
          // M inputs are still frozen by the stall, so they describe this access.
          if (dmem_ack) begin
            regwrite_q  <= RegWrite_M;
            resultsrc_q <= ResultSrc_M;
            alu_q       <= AluResult_M;
            pc4_q       <= PCPlus4_M;
            rd_q        <= RD_M;
            if (load_q) rdata_q <= dmem_rdata;
          end else begin
            regwrite_q <= 1'b0;
          end
        end
        default: regwrite_q <= 1'b0;
      endcase
    end
  end

  assign dmem_req   = (state_q == BUSY);
  assign dmem_we    = (state_q == BUSY) & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  assign RegWrite_W  = regwrite_q;
  assign ResultSrc_W = resultsrc_q;
  assign AluResult_W = alu_q;
  assign ReadData_W  = rdata_q;
  assign PCPlus4_W   = pc4_q;
  assign RD_W        = rd_q;
  assign Misalign_W  = misalign_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: vector table for pass-through, scoreboard for W results.
`timescale 1ns/1ps
module tb_memory_cycle;
  localparam int XLEN = 32;
  localparam int RDW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            RegWrite_M, ResultSrc_M, MemWrite_M;
  logic [XLEN-1:0] AluResult_M, WriteData_M, PCPlus4_M;
  logic [RDW-1:0]  RD_M;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            Stall_M;
  logic            RegWrite_W, ResultSrc_W, Misalign_W;
  logic [XLEN-1:0] AluResult_W, ReadData_W, PCPlus4_W;
  logic [RDW-1:0]  RD_W;

  always #5 clk = ~clk;

  memory_cycle #(.XLEN(XLEN), .RDW(RDW)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M), .MemWrite_M(MemWrite_M),
    .AluResult_M(AluResult_M), .WriteData_M(WriteData_M), .RD_M(RD_M), .PCPlus4_M(PCPlus4_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .Stall_M(Stall_M),
    .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W), .AluResult_W(AluResult_W),
    .ReadData_W(ReadData_W), .PCPlus4_W(PCPlus4_W), .RD_W(RD_W), .Misalign_W(Misalign_W)
  );

  typedef struct {
    logic            rw, rs, ack;
    logic [XLEN-1:0] alu, pc;
    logic [RDW-1:0]  rd;
    logic            exp_rw, exp_rs;
  } vec_t;

  typedef struct {
    logic            rw, rs, mis;
    logic [XLEN-1:0] alu, rdata, pc;
    logic [RDW-1:0]  rd;
  } wexp_t;

  vec_t            vecs [6];
  wexp_t           sb [$];
  logic [XLEN-1:0] rd_model;
  int              n_cmp = 0;
  int              n_err = 0;
  int              stalls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w();
    wexp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk("RegWrite_W",  32'(RegWrite_W),  32'(e.rw));
    chk("ResultSrc_W", 32'(ResultSrc_W), 32'(e.rs));
    chk("Misalign_W",  32'(Misalign_W),  32'(e.mis));
    chk("AluResult_W", AluResult_W, e.alu);
    chk("ReadData_W",  ReadData_W,  e.rdata);
    chk("PCPlus4_W",   PCPlus4_W,   e.pc);
    chk("RD_W",        32'(RD_W),   32'(e.rd));
  endtask

  task automatic drive_nop();
    RegWrite_M = 0; ResultSrc_M = 0; MemWrite_M = 0;
    AluResult_M = '0; WriteData_M = '0; RD_M = '0; PCPlus4_M = '0;
  endtask

  task automatic check_w_zero(input string tag);
    chk({tag, "_RegWrite_W"}, 32'(RegWrite_W), 32'd0);
    chk({tag, "_AluResult_W"}, AluResult_W, 32'd0);
    chk({tag, "_ReadData_W"}, ReadData_W, 32'd0);
    chk({tag, "_PCPlus4_W"}, PCPlus4_W, 32'd0);
    chk({tag, "_RD_W"}, 32'(RD_W), 32'd0);
  endtask

  task automatic apply_vec(input int i);
    wexp_t e;
    @(negedge clk);
    RegWrite_M = vecs[i].rw; ResultSrc_M = vecs[i].rs; MemWrite_M = 1'b0;
    AluResult_M = vecs[i].alu; WriteData_M = 32'hFFFF_0000 + 32'(i);
    RD_M = vecs[i].rd; PCPlus4_M = vecs[i].pc;
    dmem_ack = vecs[i].ack; dmem_rdata = 32'hBAD0_0000 + 32'(i);
    #1 chk("alu_stall", 32'(Stall_M), 32'd0);
    e = '{rw: vecs[i].exp_rw, rs: vecs[i].exp_rs, mis: 1'b0, alu: vecs[i].alu,
          rdata: rd_model, pc: vecs[i].pc, rd: vecs[i].rd};
    sb.push_back(e);
    @(posedge clk); #1;
    chk("alu_req", 32'(dmem_req), 32'd0);
    check_w();
    dmem_ack = 1'b0;
  endtask

  task automatic mem_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [RDW-1:0] rd, input logic [31:0] pc, input int waits,
                            input logic [31:0] rdata, output int n_stall);
    wexp_t e;
    logic  ld;
    ld = ~we;
    @(negedge clk);
    RegWrite_M = ld; ResultSrc_M = ld; MemWrite_M = we;
    AluResult_M = addr; WriteData_M = wd; RD_M = rd; PCPlus4_M = pc;
    dmem_ack = 1'b0;
    #1 chk("issue_stall", 32'(Stall_M), 32'd1);
    n_stall = 1;
    @(posedge clk); #1;
    chk("issue_bubble_rw", 32'(RegWrite_W), 32'd0);
    for (int i = 0; i <= waits; i++) begin
      chk("busy_req", 32'(dmem_req), 32'd1);
      chk("busy_addr", dmem_addr, addr);
      chk("busy_we", 32'(dmem_we), 32'(we));
      if (we) chk("busy_wdata", dmem_wdata, wd);
      @(negedge clk);
      if (i < waits) begin
        #1 chk("wait_stall", 32'(Stall_M), 32'd1);
        n_stall++;
      end else begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1 chk("ack_stall", 32'(Stall_M), 32'd0);
        if (ld) rd_model = rdata;
        e = '{rw: ld, rs: ld, mis: 1'b0, alu: addr, rdata: rd_model, pc: pc, rd: rd};
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (i < waits) chk("wait_bubble_rw", 32'(RegWrite_W), 32'd0);
    end
    dmem_ack = 1'b0;
    chk("gap_req", 32'(dmem_req), 32'd0);
    chk("gap_we", 32'(dmem_we), 32'd0);
    check_w();
  endtask

  initial begin
    vecs[0] = '{rw: 1, rs: 0, ack: 0, alu: 32'h0000_1234, pc: 32'h0000_0010, rd: 5,  exp_rw: 1, exp_rs: 0};
    vecs[1] = '{rw: 0, rs: 0, ack: 0, alu: 32'hFFFF_FFFF, pc: 32'h0000_0014, rd: 31, exp_rw: 0, exp_rs: 0};
    vecs[2] = '{rw: 0, rs: 1, ack: 0, alu: 32'h0000_0103, pc: 32'h0000_0018, rd: 1,  exp_rw: 0, exp_rs: 1};
    vecs[3] = '{rw: 1, rs: 0, ack: 1, alu: 32'h8000_0001, pc: 32'h0000_001C, rd: 12, exp_rw: 1, exp_rs: 0};
    vecs[4] = '{rw: 1, rs: 0, ack: 1, alu: 32'h5555_AAAA, pc: 32'h0000_0040, rd: 3,  exp_rw: 1, exp_rs: 0};
    vecs[5] = '{rw: 0, rs: 1, ack: 0, alu: 32'h0000_0000, pc: 32'h0000_0044, rd: 0,  exp_rw: 0, exp_rs: 1};

    // Reset held for two cycles while a load is presented.
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'hCAFE_F00D;
    RegWrite_M = 1; ResultSrc_M = 1; MemWrite_M = 0;
    AluResult_M = 32'h40; WriteData_M = 32'h1; RD_M = 4; PCPlus4_M = 32'h8;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall_memop", 32'(Stall_M), 32'd1);
      check_w_zero("rst");
    end
    @(negedge clk);
    rst = 1'b0;
    drive_nop();
    rd_model = '0;
    #1 chk("post_rst_stall", 32'(Stall_M), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_req", 32'(dmem_req), 32'd0);

    for (int i = 0; i < 4; i++) apply_vec(i);

    mem_access(1'b0, 32'h0000_0100, 32'h0, 5'd10, 32'h0000_0024, 3, 32'hDEAD_BEEF, stalls);
    chk("load_stall_cycles", 32'(stalls), 32'd4);
    mem_access(1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 32'h0000_0028, 0, 32'h1111_2222, stalls);
    chk("store_stall_cycles", 32'(stalls), 32'd1);
    mem_access(1'b0, 32'h0000_0204, 32'h0, 5'd11, 32'h0000_002C, 1, 32'h0BAD_CAFE, stalls);
    chk("b2b_load_stall_cycles", 32'(stalls), 32'd2);

    for (int i = 4; i < 6; i++) apply_vec(i);

    // Reset in the second BUSY cycle, then a late ack.
    @(negedge clk);
    RegWrite_M = 1; ResultSrc_M = 1; MemWrite_M = 0;
    AluResult_M = 32'h300; WriteData_M = 32'h0; RD_M = 7; PCPlus4_M = 32'h30;
    @(posedge clk); #1;
    chk("midrst_busy1_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    chk("midrst_busy2_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    check_w_zero("midrst");
    rd_model = '0;
    @(negedge clk);
    rst = 1'b0;
    drive_nop();
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1 chk("late_ack_stall", 32'(Stall_M), 32'd0);
    @(posedge clk); #1;
    chk("late_ack_req", 32'(dmem_req), 32'd0);
    check_w_zero("late_ack");
    @(negedge clk);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("late_ack_req2", 32'(dmem_req), 32'd0);
    chk("late_ack_rdata", ReadData_W, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    RegWrite_M = 1; ResultSrc_M = 1; MemWrite_M = 0;
    AluResult_M = 32'h102; WriteData_M = 32'h0; RD_M = 9; PCPlus4_M = 32'h50;
    #1 chk("mis_stall", 32'(Stall_M), 32'd0);
    @(posedge clk); #1;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_flag", 32'(Misalign_W), 32'd1);
    chk("mis_rw", 32'(RegWrite_W), 32'd0);
    @(negedge clk);
    drive_nop();
    @(posedge clk); #1;
    chk("mis_flag_clear", 32'(Misalign_W), 32'd0);
    chk("mis_req2", 32'(dmem_req), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
